// File: rtl/majority_run_detector_if.sv
// Sample/result bundle for majority_run_detector.
//
// Handshake: there is no backpressure. in_val qualifies in_data for one
// cycle; every cycle with in_val=1 is one consumed sample. The result
// signals are registered and always valid; they hold between samples.
// dbg_state mirrors the detector FSM (0=IDLE, 1=COUNTING, 2=DETECTED).
interface majority_run_detector_if #(
    parameter int NBITS = 3,
    parameter int EVW   = 8
);
    localparam int PW = $clog2(NBITS + 1);

    logic             in_val;
    logic [NBITS-1:0] in_data;
    logic             clr;
    logic [PW-1:0]    pop;
    logic             match;
    logic             detect;
    logic             active;
    logic [EVW-1:0]   events;
    logic [1:0]       dbg_state;

    // Sample source / result observer.
    modport master (
        output in_val, in_data, clr,
        input  pop, match, detect, active, events, dbg_state
    );

    // The detector itself.
    modport slave (
        input  in_val, in_data, clr,
        output pop, match, detect, active, events, dbg_state
    );
endinterface

// File: rtl/majority_run_detector.sv
// majority_run_detector: counts set bits of each valid sample, flags samples
// with at least THRESH set bits, and detects RUN consecutive flagged samples
// (bubbles with in_val=0 do not break a run). Each detection pulses detect
// for one cycle and bumps the events counter.
//
// Optional build macro MAJORITY_RUN_DETECTOR_SATURATE_EN: when defined the
// events counter saturates at all-ones, otherwise it wraps.
module majority_run_detector #(
    parameter int NBITS  = 3,
    parameter int THRESH = 2,
    parameter int RUN    = 2,
    parameter int EVW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    majority_run_detector_if.slave bus
);
    localparam int PW = $clog2(NBITS + 1);
    localparam int RW = $clog2(RUN + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DETECTED = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [RW-1:0]   run_q, run_n;
    logic            det_n;
    logic [PW-1:0]   pop_c;
    logic            match_c;
    logic [PW-1:0]   pop_q;
    logic            match_q;
    logic            detect_q;
    logic [EVW-1:0]  events_q;

    // Population count of the incoming sample and its threshold test.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < NBITS; i++) begin
            pop_c = pop_c + PW'(bus.in_data[i]);
        end
        match_c = (32'(pop_c) >= THRESH);
    end

    // Next state, next run count and detection pulse for this sample.
    always_comb begin
        state_n = state_q;
        run_n   = run_q;
        det_n   = 1'b0;
        if (bus.in_val) begin
            if (match_c) begin
                unique case (state_q)
                    IDLE: begin
                        run_n = RW'(1);
                        if (RUN == 1) begin
                            state_n = DETECTED;
                            det_n   = 1'b1;
                        end else begin
                            state_n = COUNTING;
                        end
                    end
                    COUNTING: begin
                        // The run count is always below RUN here, so it
                        // cannot overflow its RW bits.
                        run_n = run_q + 1'b1;
                        if (32'(run_q) + 1 == RUN) begin
                            state_n = DETECTED;
                            det_n   = 1'b1;
                        end
                    end
                    DETECTED: begin
                        // Stay detected; no new pulse until the run breaks.
                        run_n = run_q;
                    end
                    default: begin
                        state_n = IDLE;
                        run_n   = '0;
                    end
                endcase
            end else begin
                state_n = IDLE;
                run_n   = '0;
            end
        end
    end

    // State, run counter and registered sample results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            run_q    <= '0;
            pop_q    <= '0;
            match_q  <= 1'b0;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            run_q    <= run_n;
            detect_q <= det_n;
            if (bus.in_val) begin
                pop_q   <= pop_c;
                match_q <= match_c;
            end
        end
    end

    // Detection event counter; clr beats a coincident detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            events_q <= '0;
        end else if (bus.clr) begin
            events_q <= '0;
        end else if (det_n) begin
`ifdef MAJORITY_RUN_DETECTOR_SATURATE_EN
            if (events_q != {EVW{1'b1}}) begin
                events_q <= events_q + 1'b1;
            end
`else
            events_q <= events_q + 1'b1;
`endif
        end
    end

    assign bus.pop       = pop_q;
    assign bus.match     = match_q;
    assign bus.detect    = detect_q;
    assign bus.active    = (state_q == DETECTED);
    assign bus.events    = events_q;
    assign bus.dbg_state = state_q;
endmodule
